// File: rtl/sonar_pkg.sv
// Shared sonar receive-path definitions: echo FSM states and default timing/threshold values.
package sonar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_BLANK   = 3'd1,
      ST_LISTEN  = 3'd2,
      ST_CONFIRM = 3'd3,
      ST_DONE    = 3'd4
   } echo_state_t;

   localparam int unsigned DEF_DATA_WIDTH     = 16;
   localparam int unsigned DEF_TIME_WIDTH     = 24;
   localparam int unsigned DEF_BLANK_CYCLES   = 50000;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 524288;
   localparam int unsigned DEF_HI_THRESH      = 5000;
   localparam int unsigned DEF_LO_THRESH      = 3000;
   localparam int unsigned DEF_CONFIRM_COUNT  = 4;

endpackage

// File: rtl/echo_envelope.sv
// Registered rectifier: env = |sample| (most negative saturates to most positive),
// carrying the valid bit and the timer value of the cycle the sample was presented.
// Ports: clk_in, rst_n, sample_in/sample_valid_in/timer_in -> env_out/env_valid_out/env_time_out.
module echo_envelope
   import sonar_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned TIME_WIDTH = DEF_TIME_WIDTH
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid_in,
   input  logic [TIME_WIDTH-1:0] timer_in,
   output logic [DATA_WIDTH-1:0] env_out,
   output logic                  env_valid_out,
   output logic [TIME_WIDTH-1:0] env_time_out
);

   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] abs_c;

   // Two's-complement magnitude with saturation of the one unrepresentable value
   always_comb begin
      abs_c = sample_in;
      if (sample_in == MIN_NEG)
         abs_c = MAX_POS;
      else if (sample_in[DATA_WIDTH-1])
         abs_c = (~sample_in) + ONE;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         env_out       <= '0;
         env_valid_out <= 1'b0;
         env_time_out  <= '0;
      end else begin
         env_out       <= abs_c;
         env_valid_out <= sample_valid_in;
         env_time_out  <= timer_in;
      end
   end

endmodule

// File: rtl/echo_detector.sv
// Echo detector: blanks transmit ring-down, confirms an echo with hysteresis and a
// consecutive-sample run, and reports one result (tof + peak, or timeout) per burst.
// Ports: clk_in, rst_n, burst_start_in, sample_in, sample_valid_in ->
//        echo_detected_out, result_valid_out, timeout_out, tof_cycles_out, peak_out, busy_out.
module echo_detector
   import sonar_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned TIME_WIDTH     = DEF_TIME_WIDTH,
   parameter int unsigned BLANK_CYCLES   = DEF_BLANK_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned HI_THRESH      = DEF_HI_THRESH,
   parameter int unsigned LO_THRESH      = DEF_LO_THRESH,
   parameter int unsigned CONFIRM_COUNT  = DEF_CONFIRM_COUNT
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic                  burst_start_in,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid_in,
   output logic                  echo_detected_out,
   output logic                  result_valid_out,
   output logic                  timeout_out,
   output logic [TIME_WIDTH-1:0] tof_cycles_out,
   output logic [DATA_WIDTH-1:0] peak_out,
   output logic                  busy_out
);

   localparam int unsigned CNT_W = $clog2(CONFIRM_COUNT + 1);
   localparam logic [TIME_WIDTH-1:0] BLANK_T   = TIME_WIDTH'(BLANK_CYCLES);
   localparam logic [TIME_WIDTH-1:0] TIMEOUT_T = TIME_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [TIME_WIDTH-1:0] TO_EDGE_T = TIME_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] HI_T      = DATA_WIDTH'(HI_THRESH);
   localparam logic [DATA_WIDTH-1:0] LO_T      = DATA_WIDTH'(LO_THRESH);
   localparam logic [CNT_W-1:0]      CONF_T    = CNT_W'(CONFIRM_COUNT);

   echo_state_t state_q, state_d;

   logic [TIME_WIDTH-1:0] timer_q, timer_d, start_q, start_d, tof_d;
   logic [DATA_WIDTH-1:0] peak_q, peak_d, peak_out_d;
   logic [CNT_W-1:0]      count_q, count_d, cnt_inc_c;
   logic                  result_d, timeout_d, busy_d, echo_d;

   logic [DATA_WIDTH-1:0] env;
   logic                  env_valid;
   logic [TIME_WIDTH-1:0] env_time;

   logic env_ok_c, hit_c, miss_c, done_c, to_hit_c;
   logic [DATA_WIDTH-1:0] run_peak_c;

   echo_envelope #(
      .DATA_WIDTH (DATA_WIDTH),
      .TIME_WIDTH (TIME_WIDTH)
   ) u_env (
      .clk_in          (clk_in),
      .rst_n           (rst_n),
      .sample_in       (sample_in),
      .sample_valid_in (sample_valid_in),
      .timer_in        (timer_q),
      .env_out         (env),
      .env_valid_out   (env_valid),
      .env_time_out    (env_time)
   );

   // Qualified envelope events; samples tagged inside the blanking window never count
   assign env_ok_c   = env_valid && (env_time >= BLANK_T);
   assign hit_c      = env_ok_c && (env >= HI_T);
   assign miss_c     = env_ok_c && (env < HI_T);
   assign cnt_inc_c  = (state_q == ST_LISTEN) ? CNT_W'(1) : count_q + CNT_W'(1);
   assign done_c     = hit_c && (cnt_inc_c >= CONF_T);
   // Registered result lands on the cycle the timer reads TIMEOUT_CYCLES
   assign to_hit_c   = (timer_q >= TO_EDGE_T);
   assign run_peak_c = ((state_q == ST_LISTEN) || (env > peak_q)) ? env : peak_q;

   // State register
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; burst_start aborts from any state
   always_comb begin
      state_d = state_q;
      if (burst_start_in) begin
         state_d = ST_BLANK;
      end else begin
         case (state_q)
            ST_BLANK:   if (timer_q >= BLANK_T) state_d = ST_LISTEN;
            ST_LISTEN: begin
               if (done_c || to_hit_c) state_d = ST_DONE;
               else if (hit_c)         state_d = ST_CONFIRM;
            end
            ST_CONFIRM: begin
               if (done_c || to_hit_c) state_d = ST_DONE;
               else if (miss_c)        state_d = ST_LISTEN;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Datapath and registered-output next values
   always_comb begin
      timer_d    = timer_q;
      count_d    = count_q;
      peak_d     = peak_q;
      start_d    = start_q;
      result_d   = 1'b0;
      timeout_d  = 1'b0;
      tof_d      = tof_cycles_out;
      peak_out_d = peak_out;
      echo_d     = echo_detected_out;
      if (burst_start_in) begin
         timer_d = '0;
         count_d = '0;
         peak_d  = '0;
      end else begin
         if ((state_q != ST_IDLE) && (timer_q < TIMEOUT_T))
            timer_d = timer_q + TIME_WIDTH'(1);
         if ((state_q == ST_LISTEN) || (state_q == ST_CONFIRM)) begin
            // Detection has priority over a coincident timeout
            if (done_c) begin
               result_d   = 1'b1;
               tof_d      = (state_q == ST_LISTEN) ? env_time : start_q;
               peak_out_d = run_peak_c;
               count_d    = '0;
            end else if (to_hit_c) begin
               result_d   = 1'b1;
               timeout_d  = 1'b1;
               tof_d      = TIMEOUT_T;
               peak_out_d = '0;
               count_d    = '0;
            end else if (hit_c) begin
               count_d = cnt_inc_c;
               peak_d  = run_peak_c;
               if (state_q == ST_LISTEN) start_d = env_time;
            end else if (miss_c) begin
               count_d = '0;
               peak_d  = '0;
            end
         end
      end
      busy_d = (state_d == ST_BLANK) || (state_d == ST_LISTEN) || (state_d == ST_CONFIRM);
      // Hysteresis level, held low while idle or blanking
      if ((state_d == ST_IDLE) || (state_d == ST_BLANK))
         echo_d = 1'b0;
      else if (env_ok_c && (env >= HI_T))
         echo_d = 1'b1;
      else if (env_ok_c && (env < LO_T))
         echo_d = 1'b0;
   end

   // Datapath and output registers
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         timer_q           <= '0;
         count_q           <= '0;
         peak_q            <= '0;
         start_q           <= '0;
         result_valid_out  <= 1'b0;
         timeout_out       <= 1'b0;
         tof_cycles_out    <= '0;
         peak_out          <= '0;
         busy_out          <= 1'b0;
         echo_detected_out <= 1'b0;
      end else begin
         timer_q           <= timer_d;
         count_q           <= count_d;
         peak_q            <= peak_d;
         start_q           <= start_d;
         result_valid_out  <= result_d;
         timeout_out       <= timeout_d;
         tof_cycles_out    <= tof_d;
         peak_out          <= peak_out_d;
         busy_out          <= busy_d;
         echo_detected_out <= echo_d;
      end
   end

endmodule
